mem_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port 8x1024 synchronous RAM (one clock, one-cycle registered read, read-old-on-write) between NREQ requesters.
- Example requesters in the decoder: the message loader (writes), the LFSR/decrypt engine (reads and writes) and the result dump (reads).
- Grants at most one access per cycle.
- Drives the RAM port directly.
- Returns read data with a per-requester valid strobe that aligns with the RAM's one-cycle latency.

---
 rtl/mem_rr_arbiter_if.sv | 32 +++
 rtl/mem_rr_arbiter.sv | 81 ++++++++
 tb/tb_mem_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side bus of the round-robin RAM arbiter.
//   req        per-requester access request, held until granted
//   req_we     per-requester write enable (1 = write, 0 = read)
//   req_addr   packed addresses, requester i at [i*AW +: AW]
//   req_wdata  packed write data, requester i at [i*DW +: DW]
//   gnt        one-hot grant, combinational
//   rvalid     one-hot read-data-valid strobe, registered
//   rdata      shared read data
// master: requester side; slave: arbiter side.
interface mem_rr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 10,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port synchronous
// RAM (one-cycle registered read, read-old-on-write) between NREQ requesters.
// At most one access is granted per cycle; read data comes back one cycle
// after the grant with a one-hot rvalid strobe naming the requester.
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       requester bus (req/req_we/req_addr/req_wdata in,
//             gnt/rvalid/rdata out)
//   mem_wr    RAM write enable
//   mem_addr  RAM address
//   mem_d_i   RAM write data
//   mem_d_o   RAM read data (registered inside the RAM)
module mem_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 10,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_rr_arbiter_if.slave      bus,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_d_i,
  input  logic [DW-1:0]        mem_d_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last_gnt;
  logic [NREQ-1:0] rd_pend;
  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] gnt_c;

  // Index base+off wrapped modulo NREQ; works for non-power-of-2 NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    return IW'(s % NREQ);
  endfunction

  // Stage 0: combinational arbitration, search starts just after last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    gnt_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[wrap_idx(last_gnt, k + 1)]) begin
        found = 1'b1;
        win   = wrap_idx(last_gnt, k + 1);
      end
    end
    if (found) gnt_c[win] = 1'b1;
  end

  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_d_i  = '0;
    if (found) begin
      mem_wr   = bus.req_we[win];
      mem_addr = bus.req_addr[int'(win)*AW +: AW];
      mem_d_i  = bus.req_wdata[int'(win)*DW +: DW];
    end
  end

  // Stage 1: rotation pointer and read-pending flags, aligned with RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= IW'(NREQ - 1);
      rd_pend  <= '0;
    end else begin
      if (found) last_gnt <= win;
      rd_pend <= gnt_c & ~bus.req_we;
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rd_pend;
  assign bus.rdata  = mem_d_o;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 10;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_i;
  logic [DW-1:0] mem_d_o;

  mem_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_d_i  (mem_d_i),
    .mem_d_o  (mem_d_o)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read, read-old-on-write.
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_d_i;
    mem_d_o <= ram[mem_addr];
  end

  // Requester stimulus state.
  bit            r_on   [NREQ];
  bit            r_we   [NREQ];
  logic [AW-1:0] r_addr [NREQ];
  logic [DW-1:0] r_data [NREQ];

  // Reference model: rotation pointer, shadow memory, one pending read.
  int            m_last;
  int            m_rdv;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] smem [0:1023];

  // Values observed at the last step.
  logic [NREQ-1:0] g_seen, rv_seen;
  logic [DW-1:0]   rd_seen;
  logic            mw_seen;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit on, input bit we, input int a, input int d);
    r_on[i]   = on;
    r_we[i]   = we;
    r_addr[i] = AW'(a);
    r_data[i] = DW'(d);
    bus.req[i]                = on;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = AW'(a);
    bus.req_wdata[i*DW +: DW] = DW'(d);
  endtask

  task automatic all_off();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_last = NREQ - 1;
    m_rdv  = -1;
  endtask

  // One clock cycle: check outputs against the model mid-cycle, advance the
  // model as the edge would, then move to just after the rising edge.
  task automatic step();
    int w;
    logic [NREQ-1:0] eg, erv;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_last + 1 + k) % NREQ;
      if (w < 0 && r_on[i]) w = i;
    end
    eg  = (w >= 0) ? NREQ'(1 << w) : '0;
    erv = (m_rdv >= 0) ? NREQ'(1 << m_rdv) : '0;
    g_seen  = bus.gnt;
    rv_seen = bus.rvalid;
    rd_seen = bus.rdata;
    mw_seen = mem_wr;
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("mem_wr", 32'(mem_wr), (w >= 0) ? 32'(r_we[w]) : 32'd0);
    check("mem_addr", 32'(mem_addr), (w >= 0) ? 32'(r_addr[w]) : 32'd0);
    check("mem_d_i", 32'(mem_d_i), (w >= 0) ? 32'(r_data[w]) : 32'd0);
    check("rvalid", 32'(bus.rvalid), 32'(erv));
    if (m_rdv >= 0) check("rdata", 32'(bus.rdata), 32'(m_rdata));
    m_rdv = -1;
    if (w >= 0) begin
      m_last = w;
      if (r_we[w]) smem[r_addr[w]] = r_data[w];
      else begin
        m_rdv   = w;
        m_rdata = smem[r_addr[w]];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] exp_g  [4];
    logic [NREQ-1:0] exp_rv [4];
    logic [DW-1:0]   exp_rd [4];
    logic [DW-1:0]   pre    [8];
    int waited, got;
    logic [NREQ-1:0] prev;
    int wait_cnt [NREQ];

    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_rv = '{3'b000, 3'b001, 3'b010, 3'b100};
    exp_rd = '{8'h00, 8'hA5, 8'h5A, 8'h3C};
    pre    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'h3C};

    // Reset state.
    rst_n = 1'b0;
    all_off();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Preload addresses 0..7 through requester 0.
    for (int a = 0; a < 8; a++) begin
      set_req(0, 1, 1, a, int'(pre[a]));
      step();
      check("pre_gnt", 32'(g_seen), 32'd1);
    end
    all_off();
    step();

    // Reset again, then all three read 5,6,7.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_req(0, 1, 0, 5, 0);
    set_req(1, 1, 0, 6, 0);
    set_req(2, 1, 0, 7, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_gnt", 32'(g_seen), 32'(exp_g[k]));
      check("rr_rvalid", 32'(rv_seen), 32'(exp_rv[k]));
      if (k > 0) check("rr_rdata", 32'(rd_seen), 32'(exp_rd[k]));
    end
    all_off();
    step();
    check("rr_rvalid4", 32'(rv_seen), 32'd1);
    check("rr_rdata4", 32'(rd_seen), 32'hA5);

    // Idle cycle, then rotation resumes after requester 0.
    step();
    check("idle_gnt", 32'(g_seen), 32'd0);
    check("idle_mem_wr", 32'(mw_seen), 32'd0);
    check("idle_rvalid", 32'(rv_seen), 32'd0);
    set_req(0, 1, 0, 5, 0);
    set_req(1, 1, 0, 6, 0);
    set_req(2, 1, 0, 7, 0);
    step();
    check("idle_resume", 32'(g_seen), 32'b010);
    all_off();
    step();
    check("idle_resume_rd", 32'(rd_seen), 32'h5A);

    // Sole requester: writes then back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1, 1, k, 8'h11 + k);
      step();
      check("sole_wr_gnt", 32'(g_seen), 32'b010);
      check("sole_wr_en", 32'(mw_seen), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1, 0, k, 0);
      step();
      check("sole_rd_gnt", 32'(g_seen), 32'b010);
      if (k > 0) begin
        check("sole_rvalid", 32'(rv_seen), 32'b010);
        check("sole_rdata", 32'(rd_seen), 32'h11 + k - 1);
      end
    end
    all_off();
    step();
    check("sole_rvalid_last", 32'(rv_seen), 32'b010);
    check("sole_rdata_last", 32'(rd_seen), 32'h14);

    // Read-after-write to address 1023.
    set_req(0, 1, 1, 1023, 8'hC3);
    step();
    check("raw_wr_gnt", 32'(g_seen), 32'b001);
    check("raw_wr_en", 32'(mw_seen), 32'd1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 1023, 0);
    step();
    check("raw_rd_gnt", 32'(g_seen), 32'b010);
    check("raw_no_wr_rvalid", 32'(rv_seen), 32'd0);
    all_off();
    step();
    check("raw_rvalid", 32'(rv_seen), 32'b010);
    check("raw_rdata", 32'(rd_seen), 32'hC3);

    // Fairness: req0 held, req2 pulsed.
    set_req(0, 1, 0, 0, 0);
    step();
    step();
    set_req(2, 1, 0, 2, 0);
    waited = 0;
    got = 0;
    for (int t = 0; t < 4 && got == 0; t++) begin
      step();
      if (g_seen[2]) got = 1;
      else waited++;
    end
    check("fair_got", 32'(got), 32'd1);
    check("fair_wait_le2", 32'(waited <= 2), 32'd1);
    prev = 3'b100;
    for (int t = 0; t < 4; t++) begin
      step();
      check("fair_alt", 32'(g_seen), (prev == 3'b001) ? 32'b100 : 32'b001);
      prev = g_seen;
    end
    all_off();
    step();

    // Reset in the cycle after a read grant.
    set_req(0, 1, 0, 6, 0);
    step();
    all_off();
    @(negedge clk);
    check("mid_rvalid_pre", 32'(bus.rvalid), 32'b001);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_rst", 32'(bus.rvalid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 1, 0, 5, 0);
    set_req(1, 1, 0, 6, 0);
    set_req(2, 1, 0, 7, 0);
    step();
    check("mid_first_gnt", 32'(g_seen), 32'b001);

    // Randomised traffic with hold-until-granted requesters.
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!r_on[i] || g_seen[i]) begin
          set_req(i, ($urandom % 4) != 0, ($urandom % 2) == 1,
                  int'($urandom % 8), int'($urandom % 256));
          wait_cnt[i] = 0;
        end
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (r_on[i]) begin
          if (g_seen[i]) check("starve", 32'(wait_cnt[i] <= NREQ - 1), 32'd1);
          else wait_cnt[i]++;
        end
      end
    end
    all_off();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
